// File: rtl/bit_sync.sv
// bit_sync: symbol-timing recovery for a sliced FM-discriminator stream.
// Each accepted sample is sliced on its sign. A phase counter restarts at
// every slice transition, and the bit is taken half a symbol later. Lock is
// gained after LOCK_EDGES consecutive on-time transitions. It is lost on an
// off-time transition, or after DROP_BITS symbol periods with no transition.
// Optional feature macro: BIT_SYNC_NRZI_EN (NRZI decode: 1 = no change since
// the previous decision). When it is undefined the bit is the raw NRZ slice.
module bit_sync #(
  parameter int WIDTH           = 10,
  parameter int SAMPLES_PER_BIT = 8,
  parameter int LOCK_EDGES      = 4,
  parameter int DROP_BITS       = 8
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    clken_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic                    dvalid_i,
  output logic                    bit_o,
  output logic                    bvalid_o,
  output logic                    lock_o
);

  localparam int SPB  = SAMPLES_PER_BIT;
  localparam int PH_W = $clog2(SPB);
  localparam int EC_W = $clog2(LOCK_EDGES + 1);
  localparam int RC_W = $clog2(DROP_BITS + 1);

  localparam logic [PH_W-1:0]         PH_ZERO = '0;
  localparam logic [PH_W-1:0]         PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(SPB - 1);
  localparam logic [PH_W-1:0]         PH_MID  = PH_W'(SPB / 2 - 1);
  localparam logic [EC_W-1:0]         EC_MAX  = EC_W'(LOCK_EDGES);
  localparam logic [RC_W-1:0]         RC_MAX  = RC_W'(DROP_BITS);
  localparam logic signed [WIDTH-1:0] ZERO    = '0;

  // Saturating increment of the on-time edge counter.
  function automatic logic [EC_W-1:0] sat_inc_ec(input logic [EC_W-1:0] v);
    return (v == EC_MAX) ? v : v + EC_W'(1);
  endfunction

  // Saturating increment of the edge-free symbol counter.
  function automatic logic [RC_W-1:0] sat_inc_rc(input logic [RC_W-1:0] v);
    return (v == RC_MAX) ? v : v + RC_W'(1);
  endfunction

  logic [PH_W-1:0] r_ph;
  logic [EC_W-1:0] r_ecnt;
  logic [RC_W-1:0] r_rcnt;
  logic            r_s_prev;
  logic            r_primed;
  logic            r_bit;
  logic            r_bvalid;
  logic            r_lock;

  logic            w_acc;
  logic            w_s;
  logic            w_edge;
  logic            w_ontime;
  logic            w_dec;
  logic            w_wrap;
  logic            w_bit;
  logic [EC_W-1:0] w_ecnt_inc;
  logic [RC_W-1:0] w_rcnt_inc;

  // Sample acceptance, slicing and timing events.
  // r_primed blocks an edge on the first sample after reset, when s_prev is not yet real.
  assign w_acc      = clken_i & dvalid_i;
  assign w_s        = (data_i >= ZERO);
  assign w_edge     = w_acc & r_primed & (w_s != r_s_prev);
  assign w_ontime   = (r_ph == PH_LAST) | (r_ph == PH_ZERO) | (r_ph == PH_ONE);
  assign w_dec      = w_acc & ~w_edge & (r_ph == PH_MID);
  assign w_wrap     = w_acc & ~w_edge & (r_ph == PH_LAST);
  assign w_ecnt_inc = sat_inc_ec(r_ecnt);
  assign w_rcnt_inc = sat_inc_rc(r_rcnt);

`ifdef BIT_SYNC_NRZI_EN
  logic r_last_s;

  // NRZI reference: the slice seen at the most recent decision point.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_last_s <= 1'b0;
    end else if (w_dec) begin
      r_last_s <= w_s;
    end
  end

  assign w_bit = (w_s == r_last_s);
`else
  assign w_bit = w_s;
`endif

  // Bit decision output: one-cycle strobe after the mid-symbol sample.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_bit    <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      r_bvalid <= w_dec;
      if (w_dec) begin
        r_bit <= w_bit;
      end
    end
  end

  // Phase tracking, edge qualification and lock management.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_ph     <= '0;
      r_ecnt   <= '0;
      r_rcnt   <= '0;
      r_s_prev <= 1'b0;
      r_primed <= 1'b0;
      r_lock   <= 1'b0;
    end else if (w_acc) begin
      r_s_prev <= w_s;
      r_primed <= 1'b1;
      if (w_edge) begin
        r_ph   <= '0;
        r_rcnt <= '0;
        if (w_ontime) begin
          r_ecnt <= w_ecnt_inc;
          if (w_ecnt_inc == EC_MAX) begin
            r_lock <= 1'b1;
          end
        end else begin
          r_ecnt <= '0;
          r_lock <= 1'b0;
        end
      end else begin
        r_ph <= (r_ph == PH_LAST) ? PH_ZERO : r_ph + PH_ONE;
        if (w_wrap) begin
          r_rcnt <= w_rcnt_inc;
          // Too long without a transition: timing can no longer be trusted.
          if (w_rcnt_inc == RC_MAX) begin
            r_lock <= 1'b0;
            r_ecnt <= '0;
          end
        end
      end
    end
  end

  assign bit_o    = r_bit;
  assign bvalid_o = r_bvalid;
  assign lock_o   = r_lock;

endmodule

// File: tb/tb_bit_sync.sv
// tb_bit_sync: directed checks of bit_sync in its default (NRZ) build with
// SAMPLES_PER_BIT=8, LOCK_EDGES=4, DROP_BITS=8.
module tb_bit_sync;

  localparam int WIDTH = 10;

  logic                    clk;
  logic                    rst_i;
  logic                    clken_i;
  logic signed [WIDTH-1:0] data_i;
  logic                    dvalid_i;
  logic                    bit_o;
  logic                    bvalid_o;
  logic                    lock_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_strb = 0;
  int s0;

  bit_sync #(
    .WIDTH(WIDTH),
    .SAMPLES_PER_BIT(8),
    .LOCK_EDGES(4),
    .DROP_BITS(8)
  ) dut (
    .clk(clk),
    .rst_i(rst_i),
    .clken_i(clken_i),
    .data_i(data_i),
    .dvalid_i(dvalid_i),
    .bit_o(bit_o),
    .bvalid_o(bvalid_o),
    .lock_o(lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic ce, input logic dv, input int v);
    clken_i  = ce;
    dvalid_i = dv;
    data_i   = WIDTH'(v);
    @(posedge clk);
    #1;
    if (bvalid_o) n_strb++;
  endtask

  task automatic push(input int v);
    cyc(1'b1, 1'b1, v);
  endtask

  task automatic push_n(input int v, input int n);
    for (int i = 0; i < n; i++) push(v);
  endtask

  // Two ignored cycles carrying the opposite sign, then one accepted sample.
  task automatic push_sparse(input int v);
    cyc(1'b1, 1'b0, -v);
    cyc(1'b1, 1'b0, -v);
    push(v);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc(1'b0, 1'b1, -100);
    cyc(1'b0, 1'b1, -100);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i    = 1'b1;
    clken_i  = 1'b0;
    dvalid_i = 1'b0;
    data_i   = '0;

    // Reset state
    do_reset();
    check("rst_bit", bit_o, 0);
    check("rst_bvalid", bvalid_o, 0);
    check("rst_lock", lock_o, 0);

    // Alternating 8 x +100 / 8 x -100 stream
    push_n(100, 3);
    check("s3_pre_bvalid", bvalid_o, 0);
    push(100);
    check("s3_bvalid", bvalid_o, 1);
    check("s3_bit", bit_o, 1);
    push(100);
    check("s4_bvalid_drop", bvalid_o, 0);
    push_n(100, 3);
    push_n(-100, 4);
    check("s11_bvalid", bvalid_o, 0);
    push(-100);
    check("s12_bvalid", bvalid_o, 1);
    check("s12_bit", bit_o, 0);
    push_n(-100, 3);
    push_n(100, 5);
    check("s20_bvalid", bvalid_o, 1);
    check("s20_bit", bit_o, 1);
    push_n(100, 3);
    push_n(-100, 8);
    check("lock_before_4th_edge", lock_o, 0);
    push(100);
    check("lock_at_4th_edge", lock_o, 1);
    push_n(100, 7);

    // Edge shifted 3 samples late drops lock; 4 on-time edges restore it
    push_n(100, 3);
    check("lock_before_late", lock_o, 1);
    push(-100);
    check("lock_after_late", lock_o, 0);
    push_n(-100, 7);
    push_n(100, 8);
    push_n(-100, 8);
    push_n(100, 8);
    check("relock_3_edges", lock_o, 0);
    push(-100);
    check("relock_4_edges", lock_o, 1);

    // No transitions: lock drops at the 8th wrap, strobes continue
    s0 = n_strb;
    push_n(-100, 63);
    check("drop_wrap7_lock", lock_o, 1);
    push(-100);
    check("drop_wrap8_lock", lock_o, 0);
    push_n(-100, 8);
    check("drop_strobes", n_strb - s0, 9);
    check("drop_bit", bit_o, 0);

    // Sparse dvalid_i and a clken_i-low gap mid-symbol
    do_reset();
    s0 = n_strb;
    push_sparse(100);
    push_sparse(100);
    push_sparse(100);
    check("sparse_no_early_strobe", n_strb - s0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, -100);
    check("clken_low_no_strobe", n_strb - s0, 0);
    check("clken_low_lock", lock_o, 0);
    push_sparse(100);
    check("sparse_s3_bvalid", bvalid_o, 1);
    check("sparse_s3_bit", bit_o, 1);
    cyc(1'b1, 1'b0, -100);
    check("sparse_strobe_width", bvalid_o, 0);

    // Reset pulse at ph=2 while locked with bit_o=1
    do_reset();
    push_n(-100, 8);
    push_n(100, 8);
    push_n(-100, 8);
    push_n(100, 8);
    push_n(-100, 3);
    check("pre_rst_lock", lock_o, 1);
    check("pre_rst_bit", bit_o, 1);
    rst_i = 1'b1;
    cyc(1'b1, 1'b1, -100);
    rst_i = 1'b0;
    check("midrst_bit", bit_o, 0);
    check("midrst_lock", lock_o, 0);
    check("midrst_bvalid", bvalid_o, 0);
    push_n(100, 2);
    check("post_rst_no_partial", bvalid_o, 0);
    push(-100);
    push_n(-100, 3);
    check("post_rst_edge_plus3", bvalid_o, 0);
    push(-100);
    check("post_rst_edge_plus4", bvalid_o, 1);
    check("post_rst_bit", bit_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
